// File: rtl/clk_pkg.sv
// Shared types and default sizing for the reference-clock tracker.
package clk_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } trk_state_e;

  localparam int CNT_W_DEF      = 16;
  localparam int TIMEOUT_DEF    = 1000;
  localparam int LOCK_COUNT_DEF = 4;

endpackage

// File: rtl/ref_clk_tracker_if.sv
// Output bundle of the reference-clock tracker: edge strobes, period report, lock status.
interface ref_clk_tracker_if
  import clk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             rise_o;
  logic             fall_o;
  logic [CNT_W-1:0] period_o;
  logic             period_vld_o;
  logic             locked_o;
  logic             lost_o;

  modport master (
    output rise_o, fall_o, period_o, period_vld_o, locked_o, lost_o
  );

  modport slave (
    input  rise_o, fall_o, period_o, period_vld_o, locked_o, lost_o
  );

endinterface

// File: rtl/sync_edge_det.sv
// Synchroniser plus rise/fall strobe generator for a slow asynchronous level.
// Define REF_GLITCH_FILTER_EN to add a 2-cycle stability filter (rejects 1-cycle pulses).
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_o,
  output logic fall_o,
  output logic rise_evt_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ref_q, ref_d;
  logic                   ref_s;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

`ifdef REF_GLITCH_FILTER_EN
  // ref_s only follows the synchronised level once two consecutive samples agree.
  logic hist_q, hist_d;
  logic filt_q, filt_d;

  always_comb begin
    hist_d = sync_q[SYNC_STAGES-1];
    filt_d = (sync_q[SYNC_STAGES-1] == hist_q) ? hist_q : filt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign ref_s = filt_q;
`else
  assign ref_s = sync_q[SYNC_STAGES-1];
`endif

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    ref_d  = ref_s;
    rise_d = ref_s & ~ref_q;
    fall_d = ~ref_s & ref_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      ref_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      ref_q  <= ref_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign rise_evt_o = rise_d;

endmodule

// File: rtl/ref_clk_tracker.sv
// Tracks a slow reference clock in the clk domain: edge strobes, period measurement, lock/loss FSM.
// Optional REF_GLITCH_FILTER_EN (in sync_edge_det) adds 2 cycles of edge latency.
module ref_clk_tracker
  import clk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int TOL         = 1,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ref_in,
  ref_clk_tracker_if.master  trk
);

  localparam int               MW         = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TOL_C      = CNT_W'(TOL);
  localparam logic [MW-1:0]    LOCK_LAST  = MW'(LOCK_COUNT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic             rise_evt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic             lost_q, lost_d;
  trk_state_e       state_q, state_d;
  logic             timeout;
  logic             match;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .din        (ref_in),
    .rise_o     (trk.rise_o),
    .fall_o     (trk.fall_o),
    .rise_evt_o (rise_evt)
  );

  // Measurement: a rise both restarts the counter and, once armed, reports the closed period.
  always_comb begin
    cnt_d        = rise_evt ? '0 : sat_inc(cnt_q);
    period_d     = period_q;
    period_vld_d = 1'b0;
    if (rise_evt && (state_q != SEARCH)) begin
      period_d     = sat_inc(cnt_q);
      period_vld_d = 1'b1;
    end
  end

  // A coincident rise wins over the timeout; a saturated period never matches.
  assign timeout = !rise_evt && (cnt_q == TIMEOUT_M1);
  assign match   = prev_vld_q && (period_q != CNT_MAX) && (abs_diff(period_q, prev_q) <= TOL_C);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    lost_d      = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (rise_evt) begin
          state_d     = ACQUIRE;
          match_cnt_d = '0;
          prev_vld_d  = 1'b0;
        end
      end
      ACQUIRE: begin
        if (period_vld_q) begin
          prev_d     = period_q;
          prev_vld_d = 1'b1;
          if (prev_vld_q) begin
            if (!match) begin
              match_cnt_d = '0;
            end else if (match_cnt_q == LOCK_LAST) begin
              state_d = LOCKED;
            end else begin
              match_cnt_d = match_cnt_q + MW'(1);
            end
          end
        end
        if (timeout) begin
          state_d     = SEARCH;
          match_cnt_d = '0;
          prev_vld_d  = 1'b0;
        end
      end
      LOCKED: begin
        if (period_vld_q) begin
          prev_d = period_q;
        end
        if ((period_vld_q && !match) || timeout) begin
          state_d     = SEARCH;
          match_cnt_d = '0;
          prev_vld_d  = 1'b0;
          lost_d      = 1'b1;
        end
      end
      default: begin
        state_d     = SEARCH;
        match_cnt_d = '0;
        prev_vld_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      match_cnt_q  <= '0;
      lost_q       <= 1'b0;
      state_q      <= SEARCH;
    end else begin
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      match_cnt_q  <= match_cnt_d;
      lost_q       <= lost_d;
      state_q      <= state_d;
    end
  end

  assign trk.period_o     = period_q;
  assign trk.period_vld_o = period_vld_q;
  assign trk.locked_o     = (state_q == LOCKED);
  assign trk.lost_o       = lost_q;

endmodule

// File: tb/tb_ref_clk_tracker.sv
// Scoreboard bench for ref_clk_tracker: stimulus rows push expected strobe cycles, a monitor pops them.
module tb_ref_clk_tracker;

  localparam int TIMEOUT = 1000;
`ifdef REF_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ref_in = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   prev_locked = 1'b0;

  int   q_rise[$];
  int   q_fall[$];
  int   q_lost[$];
  int   q_lock[$];
  int   q_unlock[$];
  exp_t q_vld[$];

  // Columns: high cycles, low cycles, period_vld expected, expected period, event
  // (0 none, 1 lock follows, 2 mismatch loss follows, 3 timeout loss after TIMEOUT).
  int tbl [37][5] = '{
    '{5, 5, 0, 0, 0},  '{5, 5, 1, 10, 0}, '{5, 5, 1, 10, 0}, '{5, 5, 1, 10, 0},
    '{5, 5, 1, 10, 0}, '{5, 5, 1, 10, 1}, '{5, 5, 1, 10, 0}, '{5, 5, 1, 10, 0},
    '{5, 7, 1, 10, 0}, '{5, 5, 1, 12, 2}, '{5, 5, 0, 0, 0},  '{5, 5, 1, 10, 0},
    '{5, 5, 1, 10, 0}, '{5, 5, 1, 10, 0}, '{5, 5, 1, 10, 0}, '{5, 5, 1, 10, 1},
    '{5, 6, 1, 10, 0}, '{5, 5, 1, 11, 0}, '{5, 6, 1, 10, 0}, '{5, 5, 1, 11, 0},
    '{5, 5, 1, 10, 0}, '{5, 1100, 1, 10, 3}, '{5, 5, 0, 0, 0}, '{5, 7, 1, 10, 0},
    '{5, 5, 1, 12, 0}, '{5, 7, 1, 10, 0}, '{5, 5, 1, 12, 0}, '{5, 7, 1, 10, 0},
    '{5, 5, 1, 12, 0}, '{5, 1100, 1, 10, 0}, '{5, 5, 0, 0, 0}, '{5, 5, 1, 10, 0},
    '{5, 5, 1, 10, 0}, '{5, 5, 1, 10, 0}, '{5, 5, 1, 10, 0}, '{5, 5, 1, 10, 1},
    '{5, 5, 1, 10, 0}
  };

  ref_clk_tracker_if #(.CNT_W(16)) trk_if ();

  ref_clk_tracker dut (
    .clk    (clk),
    .rst    (rst),
    .ref_in (ref_in),
    .trk    (trk_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: strobe at cycle %0d, expected none", name, cyc);
  endtask

  task automatic one_period(input int hi, input int lo, input int pv, input int pval, input int ev);
    int c;
    c = cyc;
    ref_in = 1'b1;
    q_rise.push_back(c + LAT);
    if (pv != 0) q_vld.push_back('{cyc: c + LAT, val: pval});
    if (ev == 1) q_lock.push_back(c + LAT + 1);
    if (ev == 2) begin
      q_lost.push_back(c + LAT + 1);
      q_unlock.push_back(c + LAT + 1);
    end
    if (ev == 3) begin
      q_lost.push_back(c + LAT + TIMEOUT);
      q_unlock.push_back(c + LAT + TIMEOUT);
    end
    repeat (hi) @(negedge clk);
    ref_in = 1'b0;
    q_fall.push_back(cyc + LAT);
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rise"},   int'(trk_if.rise_o),       0);
    chk({tag, "_fall"},   int'(trk_if.fall_o),       0);
    chk({tag, "_period"}, int'(trk_if.period_o),     0);
    chk({tag, "_pvld"},   int'(trk_if.period_vld_o), 0);
    chk({tag, "_locked"}, int'(trk_if.locked_o),     0);
    chk({tag, "_lost"},   int'(trk_if.lost_o),       0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (trk_if.rise_o) begin
        if (q_rise.size() == 0) unexpected("rise_o");
        else chk("rise_cycle", cyc, q_rise.pop_front());
      end
      if (trk_if.fall_o) begin
        if (q_fall.size() == 0) unexpected("fall_o");
        else chk("fall_cycle", cyc, q_fall.pop_front());
      end
      if (trk_if.rise_o && trk_if.fall_o) unexpected("rise_and_fall");
      if (trk_if.period_vld_o) begin
        if (q_vld.size() == 0) unexpected("period_vld_o");
        else begin
          exp_t e;
          e = q_vld.pop_front();
          chk("period_vld_cycle", cyc, e.cyc);
          chk("period_value", int'(trk_if.period_o), e.val);
        end
      end
      if (trk_if.lost_o) begin
        if (q_lost.size() == 0) unexpected("lost_o");
        else chk("lost_cycle", cyc, q_lost.pop_front());
      end
      if (trk_if.locked_o && !prev_locked) begin
        if (q_lock.size() == 0) unexpected("locked_rise");
        else chk("lock_cycle", cyc, q_lock.pop_front());
      end
      if (!trk_if.locked_o && prev_locked) begin
        if (q_unlock.size() == 0) unexpected("locked_fall");
        else chk("unlock_cycle", cyc, q_unlock.pop_front());
      end
    end
    prev_locked = trk_if.locked_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded bound");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

`ifndef REF_GLITCH_FILTER_EN
    for (int i = 1; i <= 8; i++) begin
      one_period(1, 1, (i > 1) ? 1 : 0, 2, (i == 6) ? 1 : 0);
    end
    repeat (10) @(negedge clk);
    reset_pulse();
`endif

    for (int r = 0; r < 37; r++) begin
      one_period(tbl[r][0], tbl[r][1], tbl[r][2], tbl[r][3], tbl[r][4]);
    end

    // Asynchronous reset while locked: outputs must clear before the next clock edge.
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    ref_in = 1'b1;
`ifndef REF_GLITCH_FILTER_EN
    q_rise.push_back(cyc + LAT);
    q_fall.push_back(cyc + LAT + 1);
`endif
    @(negedge clk);
    ref_in = 1'b0;
    repeat (12) @(negedge clk);

    chk("left_rise",   q_rise.size(),   0);
    chk("left_fall",   q_fall.size(),   0);
    chk("left_vld",    q_vld.size(),    0);
    chk("left_lost",   q_lost.size(),   0);
    chk("left_lock",   q_lock.size(),   0);
    chk("left_unlock", q_unlock.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ref_clk_tracker.md
Name: ref_clk_tracker

Overview:
- Receiving end of a divided or derived clock, e.g. the toggling output of a divide-by-2 stage, or an external audio/bit clock.
- Synchronises the slow reference into the system `clk` domain and emits single-cycle rise/fall strobes, so logic uses clock enables instead of clocking on the derived net.
- Measures the reference period in `clk` cycles and runs a lock/loss state machine that the music-game audio and timing logic gate on.

Parameters:
- SYNC_STAGES, 2, flip-flops in the input synchroniser (≥2).
- CNT_W, 16, width of period counter and `period_o`.
- LOCK_COUNT, 4, consecutive in-tolerance periods needed to declare lock.
- TOL, 1, max |period − previous period| in `clk` cycles still counted as matching.
- TIMEOUT, 1000, `clk` cycles without a rising edge before the reference is declared lost (must be < 2^CNT_W).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- ref_in  input  1  reference clock; asynchronous to `clk` and may be a divided copy of it.
- rise_o  output  1  one-cycle strobe per synchronised rising edge.
- fall_o  output  1  one-cycle strobe per synchronised falling edge.
- period_o  output  CNT_W  last measured rise-to-rise period in `clk` cycles.
- period_vld_o  output  1  one-cycle strobe when `period_o` updates.
- locked_o  output  1  high while in state LOCKED.
- lost_o  output  1  one-cycle strobe on the LOCKED→SEARCH transition.

Behaviour:
- Reset: all synchroniser flops and `ref_q` = 0, counter = 0, match count = 0, state = SEARCH. All outputs = 0, `period_o` = 0.
- Clock and reset: one clock (`clk`); reset `rst` is asynchronous and active-high.
- Synchroniser: `ref_in` passes through SYNC_STAGES flops to give `ref_s`, then one more register gives `ref_q`.
  - rise = `ref_s` & ~`ref_q`; fall = ~`ref_s` & `ref_q`; both registered into `rise_o` / `fall_o`.
  - Latency: `rise_o` is high in the cycle after the (SYNC_STAGES+1)th `clk` edge that samples `ref_in` high. Default: 3 edges.
  - Strobes are exactly one cycle wide; rise and fall are never both high.
- Period counter:
  - Increments every cycle and saturates at 2^CNT_W−1.
  - On a rise strobe: counter ← 0, and if a previous rise has been seen since reset/SEARCH entry, `period_o` ← counter+1 (saturating) with `period_vld_o` = 1 in the same cycle.
  - The first rise after reset or SEARCH entry only arms measurement; no `period_vld_o`.
- State machine (states SEARCH, ACQUIRE, LOCKED):
  - SEARCH: waits for the first rise, then arms measurement and goes to ACQUIRE with match count = 0.
  - ACQUIRE, each new period: if |new − previous| ≤ TOL, match count += 1; otherwise match count ← 0.
    - When match count reaches LOCK_COUNT−1 and the current period also matches, go to LOCKED.
    - Default: the 5th rise yields the 4th period and the 3rd consecutive match; the 6th rise makes 4 matches, so lock is asserted in the cycle after `period_vld_o` of the 6th rise.
    - Explicitly: `locked_o` rises the cycle after the LOCK_COUNT-th consecutive matching comparison.
  - LOCKED: `locked_o` = 1.
    - A period off by more than TOL → SEARCH with one-cycle `lost_o`.
    - Counter reaching TIMEOUT with no rise → SEARCH with `lost_o`.
    - In either case measurement is disarmed and match count cleared.
  - Timeout in ACQUIRE → SEARCH with no `lost_o`.
- Simultaneous events: a rise in the same cycle the counter hits TIMEOUT is treated as a valid rise; the timeout is ignored.
- Saturated counter: a saturated period never matches.
- Reset mid-operation: all state clears immediately (asynchronous); no strobes are emitted on reset release.

Optional Feature:
- REF_GLITCH_FILTER_EN defined:
  - A 2-cycle stability filter sits after the synchroniser; `ref_s` changes only after the synchronised level has held for 2 consecutive cycles.
  - Pulses of 1 `clk` cycle are rejected.
  - Edge latency grows by 2 cycles (default 5 edges).
- Not defined: no filter; latency as stated in Behaviour.

Decomposition:
- Package `clk_pkg`: state enum (SEARCH/ACQUIRE/LOCKED) and default constants for CNT_W, TIMEOUT, LOCK_COUNT.
- One natural sub-module: `sync_edge_det` (synchroniser, optional filter, rise/fall strobes), reusable for button inputs.
- Period counter, comparison logic and state machine stay in the top module.

Test Plan:
- `ref_in` driven as a ÷2 toggle of `clk` (period 2) → `rise_o` every 2 cycles; `period_o` = 2; `locked_o` = 1 after the 6th rise.
- `ref_in` at 5 high / 5 low → first rise 3 cycles after the input edge; `period_o` = 10; `locked_o` rises after the 6th rise; `fall_o` strobes 5 cycles after each `rise_o`.
- Locked at period 10, then one period of 12 (TOL = 1) → `lost_o` one cycle, `locked_o` = 0, state SEARCH; relock after 6 further stable rises.
- Locked, then `ref_in` held low → `lost_o` exactly TIMEOUT (1000) cycles after the last rise counter reset; no `period_vld_o`.
- Jitter alternating 10/11 (TOL = 1) → stays locked; alternating 10/12 → never locks.
- `rst` asserted mid-LOCKED → all outputs 0 asynchronously; after release a 1-cycle `ref_in` pulse gives `rise_o` without the filter and none with REF_GLITCH_FILTER_EN defined.
